t01_shift_out_driver: RTL and testbench
=======================================

// Module: t01_shift_out_driver
// PURPOSE
//  Output-direction counterpart of the board input synchronizers: serializes a parallel word
//  onto an external 74HC595-style shift register (LEDs / 7-segment). Accepts a word via
//  valid/ready, shifts it out on ser_out/sclk_out, then pulses latch_out to update the pins.
//  Sits between core display logic and the top-level output pads.
// PARAMETERS
//  WIDTH      16  bits per transfer (>=1)
//  CLK_DIV    4   clk cycles per sclk half-period (>=1)
//  MSB_FIRST  1   1: data_in[WIDTH-1] shifted first; 0: data_in[0] first
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  data_in     in   WIDTH  word to send, sampled only on accept
//  data_valid  in   1      word present on data_in
//  data_ready  out  1      driver idle; accept = data_valid & data_ready at rising clk
//  busy        out  1      transfer in progress (SETUP/HIGH/LATCH)
//  ser_out     out  1      serial data to external SER pin
//  sclk_out    out  1      shift clock to external SRCLK pin
//  latch_out   out  1      storage-register latch to external RCLK pin
// BEHAVIOUR
//  - Reset (async, any time): data_ready=1, busy=0, ser_out=0, sclk_out=0, latch_out=0,
//    state=IDLE, counters=0, shift reg=0. Reset mid-transfer discards the word; no latch pulse.
//  - All pad outputs (ser_out, sclk_out, latch_out) come straight from flops; no glitches.
//  - States: IDLE -> SETUP -> HIGH -> (SETUP | LATCH) -> IDLE.
//  - IDLE: data_ready=1, busy=0, sclk_out=0, latch_out=0, ser_out=0. On accept at edge T:
//    capture data_in, bit_cnt=0, go SETUP; from T+1 data_ready=0, busy=1.
//  - SETUP: sclk_out=0, ser_out=current bit (changes only on entry to SETUP). Lasts CLK_DIV cycles.
//  - HIGH: sclk_out=1, ser_out held. Lasts CLK_DIV cycles. On exit shift reg advances,
//    bit_cnt++; if bit_cnt reaches WIDTH go LATCH, else SETUP.
//  - LATCH: sclk_out=0, ser_out=0, latch_out=1 for CLK_DIV cycles, then IDLE.
//  - Busy duration exactly (2*WIDTH+1)*CLK_DIV cycles (WIDTH=16, CLK_DIV=4: 132).
//  - Back-to-back: data_ready high in first IDLE cycle after LATCH; accept there starts next
//    word; min gap between latch_out fall and next sclk_out rise = 1+CLK_DIV cycles.
//  - data_valid while busy ignored (not queued); data_in changes while busy have no effect.
//  - Divider counter width $clog2(CLK_DIV+1); bit counter width $clog2(WIDTH+1); both wrap
//    to 0 on phase change; no overflow possible for legal parameters.
//  - CLK_DIV=1: sclk_out toggles every clk, still exactly one setup and one high cycle per bit.
// STRUCTURE
//  - Package t01_shift_out_pkg: typedef enum logic [1:0] {IDLE, SETUP, HIGH, LATCH} state;
//    localparam defaults for WIDTH/CLK_DIV shared with top-level pad wiring.
//  - One sub-module: t01_phase_timer (counts CLK_DIV cycles, restart on phase entry,
//    asserts done on last cycle). FSM, shift reg, bit counter in this module.
// TESTING
//  - Reset: assert rst mid-idle -> all outputs at reset values same cycle, data_ready=1.
//  - Single word WIDTH=16, CLK_DIV=4, MSB_FIRST=1, data_in=16'hA5C3 -> 16 sclk rises, sampled
//    ser_out on rises = 1010_0101_1100_0011, one latch_out pulse 4 cycles, busy 132 cycles.
//  - MSB_FIRST=0, data_in=16'h0001 -> first sampled bit 1, remaining 15 bits 0.
//  - Back-to-back: hold data_valid=1 with 16'hFFFF then 16'h0000 -> second accepted first IDLE
//    cycle after LATCH; ser_out never changes while sclk_out=1.
//  - Busy ignore: pulse data_valid with 16'h1234 during HIGH of word 16'h00FF -> only 16'h00FF
//    shifted, no extra transfer.
//  - Reset mid-transfer after 7 bits -> outputs to reset immediately, no latch_out pulse; next
//    word 16'h8001 after release shifts cleanly with full 16 bits.

Source files
------------

// File: rtl/t01_shift_out_pkg.sv
// ---------------------------------------------------------------------------
// t01_shift_out_pkg
// Shared types and defaults for the serial shift-out driver that feeds an
// external 74HC595-style shift register (LEDs / 7-segment displays).
// The defaults are also used by the top-level pad wiring, so changing the
// chain length or the shift clock rate only has to happen here.
// ---------------------------------------------------------------------------
package t01_shift_out_pkg;

  // Transfer phases: IDLE -> SETUP -> HIGH -> (SETUP | LATCH) -> IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state;

  localparam int unsigned DEF_WIDTH     = 32'd16;
  localparam int unsigned DEF_CLK_DIV   = 32'd4;
  localparam bit          DEF_MSB_FIRST = 1'b1;

endpackage

// File: rtl/t01_phase_timer.sv
// ---------------------------------------------------------------------------
// t01_phase_timer
// Measures the length of one driver phase: counts CLK_DIV clk cycles and
// flags the last one. The owner clears the count whenever a phase ends (or
// while nothing is happening), so every phase starts again from zero.
//
// Ports
//   clk    in  1  system clock, rising edge
//   rst    in  1  asynchronous, active-high reset
//   clear  in  1  restart counting from zero on the next clock
//   done   out 1  current cycle is the last cycle of the phase
// ---------------------------------------------------------------------------
module t01_phase_timer
  import t01_shift_out_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);

  localparam int unsigned CW = $clog2(CLK_DIV + 32'd1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 32'd1);

  logic [CW-1:0] cnt_r;

  // Phase cycle counter; clear always wins, so it never runs past LAST_CNT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign done = (cnt_r == LAST_CNT);

endmodule

// File: rtl/t01_shift_out_driver.sv
// ---------------------------------------------------------------------------
// t01_shift_out_driver
// Serializes a parallel word onto an external 74HC595-style shift register.
// A word is taken over a valid/ready handshake, shifted out on ser_out with
// shift clock sclk_out (one SETUP and one HIGH phase of CLK_DIV cycles per
// bit), then latch_out is pulsed for CLK_DIV cycles to move the word onto the
// external pins. All pad outputs come directly from flops.
//
// Ports
//   clk         in  1      system clock, rising edge
//   rst         in  1      asynchronous, active-high reset
//   data_in     in  WIDTH  word to send, sampled only on accept
//   data_valid  in  1      word present on data_in
//   data_ready  out 1      driver idle; accept = data_valid & data_ready
//   busy        out 1      transfer in progress (SETUP/HIGH/LATCH)
//   ser_out     out 1      serial data to external SER pin
//   sclk_out    out 1      shift clock to external SRCLK pin
//   latch_out   out 1      storage latch to external RCLK pin
// ---------------------------------------------------------------------------
module t01_shift_out_driver
  import t01_shift_out_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter bit          MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             ser_out,
  output logic             sclk_out,
  output logic             latch_out
);

  localparam int unsigned BW = $clog2(WIDTH + 32'd1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 32'd1);

  state             state_r;
  state             state_next_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_next_s;
  logic [BW-1:0]    bit_cnt_r;
  logic [BW-1:0]    bit_cnt_next_s;

  logic             ready_r;
  logic             busy_r;
  logic             ser_r;
  logic             sclk_r;
  logic             latch_r;
  logic             ready_next_s;
  logic             busy_next_s;
  logic             ser_next_s;
  logic             sclk_next_s;
  logic             latch_next_s;

  logic             accept_s;
  logic             phase_done_s;
  logic             timer_clear_s;
  logic             last_bit_s;
  logic             cur_bit_s;

  // ready_r is high exactly when state_r is IDLE, so this is the handshake
  assign accept_s   = data_valid & ready_r;
  assign last_bit_s = (bit_cnt_r == LAST_BIT);

  // Hold the timer at zero while idle; every busy phase ends on done, so
  // clearing on done restarts the count on each phase entry.
  assign timer_clear_s = (state_r == IDLE) | phase_done_s;

  t01_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear_s),
    .done  (phase_done_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        if (phase_done_s) begin
          state_next_s = HIGH;
        end else begin
          state_next_s = SETUP;
        end
      end
      HIGH: begin
        if (phase_done_s) begin
          if (last_bit_s) begin
            state_next_s = LATCH;
          end else begin
            state_next_s = SETUP;
          end
        end else begin
          state_next_s = HIGH;
        end
      end
      LATCH: begin
        if (phase_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LATCH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Shift register and bit counter: load on accept, advance at the end of HIGH
  always_comb begin
    shift_next_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    if (accept_s) begin
      shift_next_s   = data_in;
      bit_cnt_next_s = '0;
    end else if ((state_r == HIGH) && phase_done_s) begin
      if (MSB_FIRST) begin
        shift_next_s = shift_r << 1'b1;
      end else begin
        shift_next_s = shift_r >> 1'b1;
      end
      if (last_bit_s) begin
        bit_cnt_next_s = '0;
      end else begin
        bit_cnt_next_s = bit_cnt_r + BW'(1);
      end
    end else begin
      shift_next_s   = shift_r;
      bit_cnt_next_s = bit_cnt_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= '0;
      bit_cnt_r <= '0;
    end else begin
      shift_r   <= shift_next_s;
      bit_cnt_r <= bit_cnt_next_s;
    end
  end

  // The bit on the wire is taken from the next shift value, so ser_out
  // changes together with the entry into SETUP and is steady through HIGH.
  always_comb begin
    if (MSB_FIRST) begin
      cur_bit_s = shift_next_s[WIDTH-1];
    end else begin
      cur_bit_s = shift_next_s[0];
    end
  end

  // Output decode from the next state, so every pad output is a flop
  always_comb begin
    ready_next_s = 1'b0;
    busy_next_s  = 1'b1;
    ser_next_s   = 1'b0;
    sclk_next_s  = 1'b0;
    latch_next_s = 1'b0;
    case (state_next_s)
      IDLE: begin
        ready_next_s = 1'b1;
        busy_next_s  = 1'b0;
      end
      SETUP: begin
        ser_next_s = cur_bit_s;
      end
      HIGH: begin
        ser_next_s  = cur_bit_s;
        sclk_next_s = 1'b1;
      end
      LATCH: begin
        latch_next_s = 1'b1;
      end
      default: begin
        ready_next_s = 1'b1;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      ser_r   <= 1'b0;
      sclk_r  <= 1'b0;
      latch_r <= 1'b0;
    end else begin
      ready_r <= ready_next_s;
      busy_r  <= busy_next_s;
      ser_r   <= ser_next_s;
      sclk_r  <= sclk_next_s;
      latch_r <= latch_next_s;
    end
  end

  assign data_ready = ready_r;
  assign busy       = busy_r;
  assign ser_out    = ser_r;
  assign sclk_out   = sclk_r;
  assign latch_out  = latch_r;

endmodule

// File: tb/tb_t01_shift_out_driver.sv
// ---------------------------------------------------------------------------
// tb_t01_shift_out_driver
// Scoreboard bench: every word expected to reach the pins is queued when it
// is driven; a monitor rebuilds each word from ser_out at sclk_out rises and
// compares it with the queue head when latch_out falls. A second instance
// with MSB_FIRST=0 covers LSB-first ordering.
// ---------------------------------------------------------------------------
module tb_t01_shift_out_driver;

  localparam int W  = 16;
  localparam int CD = 4;
  localparam int BUSY_CYCLES = (2 * W + 1) * CD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        ser_out;
  logic        sclk_out;
  logic        latch_out;

  logic [15:0] data_in2;
  logic        data_valid2;
  logic        data_ready2;
  logic        busy2;
  logic        ser2;
  logic        sclk2;
  logic        latch2;

  always #5 clk = ~clk;

  t01_shift_out_driver #(
    .WIDTH     (W),
    .CLK_DIV   (CD),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .ser_out    (ser_out),
    .sclk_out   (sclk_out),
    .latch_out  (latch_out)
  );

  t01_shift_out_driver #(
    .WIDTH     (W),
    .CLK_DIV   (CD),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in2),
    .data_valid (data_valid2),
    .data_ready (data_ready2),
    .busy       (busy2),
    .ser_out    (ser2),
    .sclk_out   (sclk2),
    .latch_out  (latch2)
  );

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [15:0] exp_q[$];

  // monitor state
  logic        sclk_q  = 1'b0;
  logic        latch_q = 1'b0;
  logic        busy_q  = 1'b0;
  logic        ser_q   = 1'b0;
  logic [15:0] acc     = 16'h0000;
  logic [15:0] exp_w;
  int          bit_count = 0;
  int          latch_len = 0;
  int          busy_len  = 0;
  int          gap       = 0;
  int          gap_b2b   = -1;
  int          n_xfer    = 0;
  int          glitches  = 0;

  // LSB-first instance capture
  logic [15:0] lsb_bits;
  logic        lsb_prev;
  int          lsb_k;
  int          lsb_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input logic lvl, input string tag);
    int n = 0;
    while (data_ready !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq({tag, "_timeout"}, {31'd0, data_ready}, {31'd0, lvl});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input bit expect_out);
    if (expect_out) exp_q.push_back(d);
    data_in    = d;
    data_valid = 1'b1;
    wait_ready(1'b1, "send");
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
    check_eq({tag, "_busy"},  {31'd0, busy},       32'd0);
    check_eq({tag, "_ser"},   {31'd0, ser_out},    32'd0);
    check_eq({tag, "_sclk"},  {31'd0, sclk_out},   32'd0);
    check_eq({tag, "_latch"}, {31'd0, latch_out},  32'd0);
  endtask

  // Monitor: rebuild words, measure latch / busy / gap timing
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        acc       = 16'h0000;
        bit_count = 0;
        latch_len = 0;
        busy_len  = 0;
        gap       = 0;
        sclk_q    = 1'b0;
        latch_q   = 1'b0;
        busy_q    = 1'b0;
        ser_q     = 1'b0;
      end else begin
        if (!latch_out && latch_q) gap = 0;
        else gap++;
        if (sclk_out && sclk_q && (ser_out !== ser_q)) glitches++;
        if (sclk_out && !sclk_q) begin
          if (bit_count == 0 && n_xfer == 2) gap_b2b = gap;
          acc = {acc[14:0], ser_out};
          bit_count++;
        end
        if (latch_out) latch_len++;
        if (!latch_out && latch_q) begin
          check_eq("latch_len", latch_len, CD);
          check_eq("bit_count", bit_count, W);
          exp_w = 16'hxxxx;
          if (exp_q.size() > 0) exp_w = exp_q.pop_front();
          check_eq("word", {16'd0, acc}, {16'd0, exp_w});
          n_xfer++;
          acc       = 16'h0000;
          bit_count = 0;
          latch_len = 0;
        end
        if (busy) busy_len++;
        if (!busy && busy_q) begin
          check_eq("busy_len", busy_len, BUSY_CYCLES);
          busy_len = 0;
        end
        sclk_q  = sclk_out;
        latch_q = latch_out;
        busy_q  = busy;
        ser_q   = ser_out;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Main sequence
  initial begin
    rst         = 1'b1;
    data_in     = 16'h0000;
    data_valid  = 1'b0;
    data_in2    = 16'h0000;
    data_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset while idle: outputs at reset values immediately
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_idle");
    check_eq("rst_idle_ready_lsb", {31'd0, data_ready2}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single word, MSB first
    send(16'hA5C3, 1'b1);
    wait_idle("a5c3");

    // back-to-back with data_valid held high
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    data_in    = 16'hFFFF;
    data_valid = 1'b1;
    wait_ready(1'b0, "b2b_acc1");
    data_in = 16'h0000;
    wait_ready(1'b1, "b2b_idle");
    wait_ready(1'b0, "b2b_acc2");
    data_valid = 1'b0;
    wait_idle("b2b");
    check_eq("b2b_gap", gap_b2b, CD + 1);

    // request while busy must be ignored
    send(16'h00FF, 1'b1);
    begin
      int n = 0;
      while (sclk_out !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) check_eq("sclk_high_timeout", {31'd0, sclk_out}, 32'd1);
    end
    data_in    = 16'h1234;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    data_in    = 16'h0000;
    wait_idle("ignore");
    repeat (20) @(negedge clk);
    check_eq("ignore_still_idle", {31'd0, busy}, 32'd0);
    check_eq("ignore_xfers", n_xfer, 4);

    // reset after 7 bits: word is discarded, no latch pulse
    send(16'hC3C3, 1'b0);
    begin
      int n = 0;
      while (bit_count != 7 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (n >= 500) check_eq("seven_bits_timeout", bit_count, 7);
    end
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_mid_xfers", n_xfer, 4);

    // clean transfer after reset
    send(16'h8001, 1'b1);
    wait_idle("8001");
    check_eq("total_xfers", n_xfer, 5);
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("ser_stable_while_sclk_high", glitches, 0);

    // LSB-first instance
    data_in2    = 16'h0001;
    data_valid2 = 1'b1;
    @(negedge clk);
    data_valid2 = 1'b0;
    data_in2    = 16'hFFFF;
    lsb_bits = 16'h0000;
    lsb_prev = 1'b0;
    lsb_k    = 0;
    lsb_n    = 0;
    while (lsb_k < 16 && lsb_n < 2000) begin
      @(negedge clk);
      lsb_n++;
      if (sclk2 && !lsb_prev) begin
        lsb_bits[lsb_k] = ser2;
        lsb_k++;
      end
      lsb_prev = sclk2;
    end
    check_eq("lsb_bits_seen", lsb_k, 16);
    check_eq("lsb_first_bit", {31'd0, lsb_bits[0]}, 32'd1);
    check_eq("lsb_rest", {17'd0, lsb_bits[15:1]}, 32'd0);
    lsb_n = 0;
    while (latch2 !== 1'b1 && lsb_n < 200) begin
      @(negedge clk);
      lsb_n++;
    end
    check_eq("lsb_latch", {31'd0, latch2}, 32'd1);
    lsb_n = 0;
    while (busy2 !== 1'b0 && lsb_n < 200) begin
      @(negedge clk);
      lsb_n++;
    end
    check_eq("lsb_idle", {31'd0, data_ready2}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
